sv32_ptw: RTL and testbench
===========================

// Module: sv32_ptw
// PURPOSE
//  Shared Sv32 page-table walker that serves I-TLB and D-TLB misses. It arbitrates between the two miss requesters and walks
//  the two-level table over one memory read port. It then writes the leaf into the requesting TLB's update_* port, or reports a
//  page fault. It sits between the TLBs and the memory arbiter. The TLBs still perform the privilege/SUM/MXR checks.
// PARAMETERS
//  XLEN     32  datapath width; only 32 (Sv32) supported
//  RR_ARB   1   1 = round-robin I/D grant; 0 = fixed D-side priority
// PORTS
//  clk              in   1   clock; single clock domain
//  reset            in   1   synchronous, active-high reset
//  satp_ppn         in   22  root table PPN (satp[21:0]); only [19:0] used (32-bit PA)
//  flush_all        in   1   SFENCE.VMA; suppresses the update of an in-flight walk
//  i_req / d_req    in   1   miss request; held high until matching *_done
//  i_vaddr/d_vaddr  in   32  faulting virtual address
//  d_is_store       in   1   D-side miss is a store (D-bit check)
//  i_done / d_done  out  1   1-cycle pulse: walk finished for that requester
//  i_fault/d_fault  out  1   valid with *_done; 1 = page fault, no update
//  i_upd_valid      out  1   1-cycle update strobe to I-TLB
//  d_upd_valid      out  1   1-cycle update strobe to D-TLB
//  upd_vpn          out  32  {12'b0, vaddr[31:12]}
//  upd_ppn          out  32  {10'b0, pte[31:10]}
//  upd_pte          out  8   pte[7:0] (V,R,W,X,U,G,A,D)
//  upd_level        out  32  0 = 4KB leaf, 1 = 4MB superpage
//  mem_req_valid    out  1   PTE read request
//  mem_req_addr     out  32  {ppn[19:0], vpn_slice[9:0], 2'b00}
//  mem_req_ready    in   1   request accepted when valid&ready
//  mem_resp_valid   in   1   read data valid (exactly one per accepted req)
//  mem_resp_data    in   32  PTE
//  mem_resp_err     in   1   bus error on read
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; all outputs 0; last_grant=I; flush_seen=0. Reset mid-walk abandons the walk.
//   Late mem_resp after reset is ignored (IDLE ignores mem_resp_*).
//  FSM: IDLE -> REQ -> WAIT -> {REQ | UPDATE | FAULT} -> IDLE.
//   IDLE: grant when i_req|d_req. Both pending with RR_ARB=1: grant the side not granted last; RR_ARB=0: grant D.
//    Latch vaddr, is_store (I-side: 0), owner, level=1, ppn=satp_ppn; flush_seen=0 -> REQ.
//   REQ: mem_req_valid=1; addr slice = vaddr[31:22] (level 1) or vaddr[21:12] (level 0); hold until mem_req_ready -> WAIT.
//   WAIT: on mem_resp_valid, check in this order:
//    err -> FAULT; !V or (W&!R) -> FAULT;
//    non-leaf (R=X=0): level 1 -> ppn=pte[31:10], level=0 -> REQ; level 0 -> FAULT;
//    leaf: level 1 and pte[19:10]!=0 (misaligned superpage) -> FAULT; !A or (is_store&!D) -> FAULT (no HW A/D update);
//    else latch upd_* -> UPDATE.
//   UPDATE (1 cycle): owner's *_upd_valid=1 unless flush_seen; owner's *_done=1, *_fault=0 -> IDLE.
//   FAULT (1 cycle): owner's *_done=1, *_fault=1; no upd strobe -> IDLE.
//  flush_all in any non-IDLE state (or same cycle as grant) sets flush_seen. The walk still completes; done is still
//   given so the requester re-looks up and re-misses. flush_all in IDLE has no effect.
//  upd_* and done are registered; upd_* hold their last value outside UPDATE. upd_valid and done coincide in one cycle.
//  Latency with a zero-wait memory (ready=1, resp next cycle): 4KB walk = 5 cycles grant->done; superpage = 3 cycles.
//  Requester deasserting req mid-walk is illegal; the walker ignores it and still pulses done.
//  Requests arriving during a walk wait in IDLE arbitration; no queueing beyond the two req lines.
//  Never more than one outstanding memory request; mem_req_valid is never high outside REQ.
// STRUCTURE
//  mmu_pkg: PTE bit indices (PTE_V..PTE_D), Sv32 constants (PAGE_SHIFT=12, VPN_BITS=10), FSM state encoding,
//   owner encoding (OWN_I/OWN_D). Shared with tlb.
//  Sub-module ptw_rr_arb: 2-way round-robin grant with last_grant register and RR_ARB mode.
//  Walker FSM, PTE checks and update registers stay in sv32_ptw.
// TESTING
//  1 4KB walk: i_req, vaddr=0x0040_3ABC, satp_ppn=0x80000; L1 PTE=0x2000_0001, L0 PTE=0x1234_50CB ->
//    reads at 0x8000_0004 then 0x8000_000C; i_upd_valid with upd_vpn=0x00403, upd_ppn=0x48D14, upd_level=0, upd_pte=0xCB; i_fault=0.
//  2 superpage: d_req, vaddr=0x0080_0000, L1 PTE=0x2000_00CF -> one read at 0x8000_0008; d_upd_valid, upd_level=1, upd_ppn=0x80000.
//    Misaligned L1 leaf 0x2000_04CF -> d_fault=1, no upd.
//  3 faults: L1 PTE V=0; W&!R; L0 non-leaf; store leaf with D=0; mem_resp_err=1 -> each: *_done&*_fault, no upd_valid.
//  4 arbitration: i_req&d_req same cycle with RR_ARB=1, last_grant=I -> D walked first, then I. Repeat -> alternates.
//    RR_ARB=0 -> D always first.
//  5 flush mid-walk: flush_all in WAIT -> done=1, fault=0, upd_valid stays 0.
//  6 reset mid-walk + backpressure: mem_req_ready=0 for 3 cycles -> addr/valid stable; reset in WAIT, late resp -> outputs 0, no done.

Source files
------------

// File: rtl/sv32_ptw_pkg.sv
// Shared Sv32 MMU definitions.
// Holds the PTE bit positions, Sv32 geometry constants, the walker FSM
// state encoding, the requester (owner) encoding and a helper that forms
// the physical address of a PTE. The TLBs import the same package, so
// both sides agree on the bit layout.
// No ports: package only.
package sv32_ptw_pkg;

  // PTE flag bit positions
  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  // Sv32 geometry
  localparam int PAGE_SHIFT  = 12;
  localparam int VPN_BITS    = 10;
  localparam int PA_PPN_BITS = 20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_FAULT  = 3'd4
  } ptw_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } ptw_owner_e;

  // Physical address of a PTE: table base page plus the 4-byte entry index.
  function automatic logic [31:0] pte_addr(input logic [PA_PPN_BITS-1:0] ppn,
                                           input logic [VPN_BITS-1:0] vpnSlice);
    return {ppn, vpnSlice, 2'b00};
  endfunction

endpackage

// File: rtl/sv32_ptw_rr_arb.sv
// Two-way I/D grant logic for the page-table walker.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   i_i_req     I-side miss pending
//   i_d_req     D-side miss pending
//   i_take      walker is idle and will accept the grant this cycle
//   o_grant     some requester is granted
//   o_grant_d   1 = D-side granted, 0 = I-side granted
// RR_ARB = 1 alternates between the two sides when both are pending;
// RR_ARB = 0 always prefers the D side.
module sv32_ptw_rr_arb
  import sv32_ptw_pkg::*;
#(
  parameter int RR_ARB = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_i_req,
  input  logic i_d_req,
  input  logic i_take,
  output logic o_grant,
  output logic o_grant_d
);

  ptw_owner_e r_lastGrant;

  assign o_grant = i_i_req | i_d_req;

  // With both sides pending, round-robin gives the side not served last.
  always_comb begin
    o_grant_d = 1'b0;
    if (i_d_req && !i_i_req) begin
      o_grant_d = 1'b1;
    end else if (i_d_req && i_i_req) begin
      if (RR_ARB != 0) begin
        o_grant_d = (r_lastGrant == OWN_I);
      end else begin
        o_grant_d = 1'b1;
      end
    end
  end

  // Remember who was served, updated only when the walker actually accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastGrant <= OWN_I;
    end else if (i_take && o_grant) begin
      r_lastGrant <= o_grant_d ? OWN_D : OWN_I;
    end
  end

endmodule

// File: rtl/sv32_ptw.sv
// Shared Sv32 page-table walker serving I-TLB and D-TLB misses.
// Walks the two-level table over one memory read port and either writes
// the leaf into the requesting TLB or reports a page fault. Privilege,
// SUM and MXR checks remain in the TLBs.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_satp_ppn[21:0]           root table PPN (only [19:0] used)
//   i_flush_all                SFENCE.VMA, suppresses update of current walk
//   i_i_req / i_d_req          miss requests, held until matching done
//   i_i_vaddr / i_d_vaddr      faulting virtual addresses
//   i_d_is_store               D-side miss is a store
//   o_i_done / o_d_done        one-cycle completion pulses
//   o_i_fault / o_d_fault      page fault, valid with done
//   o_i_upd_valid/o_d_upd_valid  one-cycle TLB update strobes
//   o_upd_vpn/ppn/pte/level    update payload, held between updates
//   o_mem_req_valid/addr       PTE read request, i_mem_req_ready accepts
//   i_mem_resp_valid/data/err  PTE read response
module sv32_ptw
  import sv32_ptw_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RR_ARB = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [21:0]     i_satp_ppn,
  input  logic            i_flush_all,
  input  logic            i_i_req,
  input  logic            i_d_req,
  input  logic [XLEN-1:0] i_i_vaddr,
  input  logic [XLEN-1:0] i_d_vaddr,
  input  logic            i_d_is_store,
  output logic            o_i_done,
  output logic            o_d_done,
  output logic            o_i_fault,
  output logic            o_d_fault,
  output logic            o_i_upd_valid,
  output logic            o_d_upd_valid,
  output logic [XLEN-1:0] o_upd_vpn,
  output logic [XLEN-1:0] o_upd_ppn,
  output logic [7:0]      o_upd_pte,
  output logic [XLEN-1:0] o_upd_level,
  output logic            o_mem_req_valid,
  output logic [XLEN-1:0] o_mem_req_addr,
  input  logic            i_mem_req_ready,
  input  logic            i_mem_resp_valid,
  input  logic [XLEN-1:0] i_mem_resp_data,
  input  logic            i_mem_resp_err
);

  ptw_state_e              r_state;
  ptw_owner_e              r_owner;
  logic [19:0]             r_vpn;
  logic [PA_PPN_BITS-1:0]  r_ppn;
  logic                    r_level;
  logic                    r_isStore;
  logic                    r_flushSeen;

  logic                    w_grant;
  logic                    w_grantD;
  logic                    w_take;
  logic [19:0]             w_grantVpn;
  logic                    w_descend;
  logic                    w_leafOk;
  logic                    w_flush;
  logic                    w_unused;

  assign w_take     = (r_state == ST_IDLE);
  assign w_grantVpn = w_grantD ? i_d_vaddr[31:PAGE_SHIFT] : i_i_vaddr[31:PAGE_SHIFT];
  assign w_flush    = r_flushSeen | i_flush_all;

  // Bits that the 32-bit PA and the PTE layout never look at.
  assign w_unused = ^{i_satp_ppn[21:20], i_i_vaddr[PAGE_SHIFT-1:0],
                      i_d_vaddr[PAGE_SHIFT-1:0], i_mem_resp_data[9:8]};

  sv32_ptw_rr_arb #(
    .RR_ARB (RR_ARB)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_i_req   (i_i_req),
    .i_d_req   (i_d_req),
    .i_take    (w_take),
    .o_grant   (w_grant),
    .o_grant_d (w_grantD)
  );

  // Classify the returned PTE. The priority order matters: a bus error or
  // an invalid encoding faults before the leaf/pointer decision, and the
  // superpage alignment check precedes the A/D check. Anything that is
  // neither a descend nor a good leaf is a fault.
  always_comb begin
    w_descend = 1'b0;
    w_leafOk  = 1'b0;
    if (i_mem_resp_err) begin
      w_descend = 1'b0;
    end else if (!i_mem_resp_data[PTE_V] ||
                 (i_mem_resp_data[PTE_W] && !i_mem_resp_data[PTE_R])) begin
      w_descend = 1'b0;
    end else if (!i_mem_resp_data[PTE_R] && !i_mem_resp_data[PTE_X]) begin
      w_descend = r_level;
    end else if (r_level && (i_mem_resp_data[19:10] != 10'd0)) begin
      w_leafOk = 1'b0;
    end else if (!i_mem_resp_data[PTE_A] ||
                 (r_isStore && !i_mem_resp_data[PTE_D])) begin
      w_leafOk = 1'b0;
    end else begin
      w_leafOk = 1'b1;
    end
  end

  // Walker FSM. Done, fault and update strobes are raised on the edge that
  // enters UPDATE/FAULT, so they are visible exactly while in that state.
  // Hardware A/D updating is not done; a missing A or D bit is a fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_owner         <= OWN_I;
      r_vpn           <= '0;
      r_ppn           <= '0;
      r_level         <= 1'b0;
      r_isStore       <= 1'b0;
      r_flushSeen     <= 1'b0;
      o_i_done        <= 1'b0;
      o_d_done        <= 1'b0;
      o_i_fault       <= 1'b0;
      o_d_fault       <= 1'b0;
      o_i_upd_valid   <= 1'b0;
      o_d_upd_valid   <= 1'b0;
      o_upd_vpn       <= '0;
      o_upd_ppn       <= '0;
      o_upd_pte       <= '0;
      o_upd_level     <= '0;
      o_mem_req_valid <= 1'b0;
      o_mem_req_addr  <= '0;
    end else begin
      o_i_done      <= 1'b0;
      o_d_done      <= 1'b0;
      o_i_fault     <= 1'b0;
      o_d_fault     <= 1'b0;
      o_i_upd_valid <= 1'b0;
      o_d_upd_valid <= 1'b0;

      if (i_flush_all && (r_state != ST_IDLE)) begin
        r_flushSeen <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_owner         <= w_grantD ? OWN_D : OWN_I;
            r_vpn           <= w_grantVpn;
            r_isStore       <= w_grantD & i_d_is_store;
            r_level         <= 1'b1;
            r_ppn           <= i_satp_ppn[PA_PPN_BITS-1:0];
            r_flushSeen     <= i_flush_all;
            o_mem_req_valid <= 1'b1;
            o_mem_req_addr  <= pte_addr(i_satp_ppn[PA_PPN_BITS-1:0], w_grantVpn[19:10]);
            r_state         <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (i_mem_req_ready) begin
            o_mem_req_valid <= 1'b0;
            r_state         <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (i_mem_resp_valid) begin
            if (w_descend) begin
              r_ppn           <= i_mem_resp_data[29:10];
              r_level         <= 1'b0;
              o_mem_req_valid <= 1'b1;
              o_mem_req_addr  <= pte_addr(i_mem_resp_data[29:10], r_vpn[VPN_BITS-1:0]);
              r_state         <= ST_REQ;
            end else if (w_leafOk) begin
              o_upd_vpn   <= {12'd0, r_vpn};
              o_upd_ppn   <= {10'd0, i_mem_resp_data[31:10]};
              o_upd_pte   <= i_mem_resp_data[7:0];
              o_upd_level <= {31'd0, r_level};
              if (r_owner == OWN_D) begin
                o_d_done      <= 1'b1;
                o_d_upd_valid <= !w_flush;
              end else begin
                o_i_done      <= 1'b1;
                o_i_upd_valid <= !w_flush;
              end
              r_state <= ST_UPDATE;
            end else begin
              if (r_owner == OWN_D) begin
                o_d_done  <= 1'b1;
                o_d_fault <= 1'b1;
              end else begin
                o_i_done  <= 1'b1;
                o_i_fault <= 1'b1;
              end
              r_state <= ST_FAULT;
            end
          end
        end

        ST_UPDATE: r_state <= ST_IDLE;
        ST_FAULT:  r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sv32_ptw.sv
// Directed self-checking bench for sv32_ptw.
// A second instance with fixed D priority checks the non-round-robin grant.
module tb_sv32_ptw;
  logic        clk;
  logic        reset;
  logic [21:0] satpPpn;
  logic        flushAll;
  logic        iReq, dReq, iReq0, dReq0;
  logic [31:0] iVaddr, dVaddr;
  logic        dIsStore;
  logic        memReqReady, memRespValid, memRespErr;
  logic [31:0] memRespData;

  logic        iDone, dDone, iFault, dFault, iUpd, dUpd, memReqValid;
  logic [31:0] updVpn, updPpn, updLevel, memReqAddr;
  logic [7:0]  updPte;
  logic        aIDone, aDDone, aIFault, aDFault, aIUpd, aDUpd, aMemReqValid;
  logic [31:0] aUpdVpn, aUpdPpn, aUpdLevel, aMemReqAddr;
  logic [7:0]  aUpdPte;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0 = 0;

  sv32_ptw #(.XLEN(32), .RR_ARB(1)) dut (
    .clk(clk), .reset(reset), .i_satp_ppn(satpPpn), .i_flush_all(flushAll),
    .i_i_req(iReq), .i_d_req(dReq), .i_i_vaddr(iVaddr), .i_d_vaddr(dVaddr),
    .i_d_is_store(dIsStore),
    .o_i_done(iDone), .o_d_done(dDone), .o_i_fault(iFault), .o_d_fault(dFault),
    .o_i_upd_valid(iUpd), .o_d_upd_valid(dUpd),
    .o_upd_vpn(updVpn), .o_upd_ppn(updPpn), .o_upd_pte(updPte), .o_upd_level(updLevel),
    .o_mem_req_valid(memReqValid), .o_mem_req_addr(memReqAddr),
    .i_mem_req_ready(memReqReady), .i_mem_resp_valid(memRespValid),
    .i_mem_resp_data(memRespData), .i_mem_resp_err(memRespErr));

  sv32_ptw #(.XLEN(32), .RR_ARB(0)) dutFixed (
    .clk(clk), .reset(reset), .i_satp_ppn(satpPpn), .i_flush_all(flushAll),
    .i_i_req(iReq0), .i_d_req(dReq0), .i_i_vaddr(iVaddr), .i_d_vaddr(dVaddr),
    .i_d_is_store(dIsStore),
    .o_i_done(aIDone), .o_d_done(aDDone), .o_i_fault(aIFault), .o_d_fault(aDFault),
    .o_i_upd_valid(aIUpd), .o_d_upd_valid(aDUpd),
    .o_upd_vpn(aUpdVpn), .o_upd_ppn(aUpdPpn), .o_upd_pte(aUpdPte), .o_upd_level(aUpdLevel),
    .o_mem_req_valid(aMemReqValid), .o_mem_req_addr(aMemReqAddr),
    .i_mem_req_ready(memReqReady), .i_mem_resp_valid(memRespValid),
    .i_mem_resp_data(memRespData), .i_mem_resp_err(memRespErr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic iR, input logic dR, input logic [31:0] iVa,
                               input logic [31:0] dVa, input logic store);
    iReq = iR; dReq = dR; iVaddr = iVa; dVaddr = dVa; dIsStore = store;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // exp = {iDone, iFault, iUpd, dDone, dFault, dUpd}
  task automatic checkStrobes(input bit alt, input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = alt ? {aIDone, aIFault, aIUpd, aDDone, aDFault, aDUpd}
              : {iDone, iFault, iUpd, dDone, dFault, dUpd};
    checkOutput(tag, {26'd0, obs}, {26'd0, exp});
  endtask

  // Zero-wait memory: check the request, accept it, answer next cycle.
  task automatic serveRead(input bit alt, input string tag, input logic [31:0] expAddr,
                           input logic [31:0] data, input logic err, input logic flushIt);
    int n;
    n = 0;
    while (!(alt ? aMemReqValid : memReqValid) && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_reqValid"}, {31'd0, alt ? aMemReqValid : memReqValid}, 32'd1);
    checkOutput({tag, "_addr"}, alt ? aMemReqAddr : memReqAddr, expAddr);
    tick();
    memRespValid = 1'b1; memRespData = data; memRespErr = err; flushAll = flushIt;
    tick();
    memRespValid = 1'b0; memRespErr = 1'b0; flushAll = 1'b0;
  endtask

  initial begin
    reset = 1'b1; satpPpn = 22'h080000; flushAll = 1'b0;
    iReq0 = 1'b0; dReq0 = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    memReqReady = 1'b1; memRespValid = 1'b0; memRespErr = 1'b0; memRespData = 32'h0;
    tick(); tick();
    checkStrobes(1'b0, "reset_strobes", 6'b000000);
    checkOutput("reset_reqValid", {31'd0, memReqValid}, 32'd0);
    checkOutput("reset_updVpn", updVpn, 32'd0);
    reset = 1'b0;
    tick();

    // flush while idle must not disturb the following walk
    flushAll = 1'b1; tick(); flushAll = 1'b0;

    // 4KB walk on the I side
    applyStimulus(1'b1, 1'b0, 32'h0040_3ABC, 32'h0, 1'b0);
    c0 = cyc; tick();
    serveRead(1'b0, "t1_l1", 32'h8000_0004, 32'h2000_0001, 1'b0, 1'b0);
    serveRead(1'b0, "t1_l0", 32'h8000_000C, 32'h1234_50CB, 1'b0, 1'b0);
    checkStrobes(1'b0, "t1_done", 6'b101000);
    checkOutput("t1_latency", cyc - c0, 32'd5);
    checkOutput("t1_updVpn", updVpn, 32'h0000_0403);
    checkOutput("t1_updPpn", updPpn, 32'h0004_8D14);
    checkOutput("t1_updLevel", updLevel, 32'd0);
    checkOutput("t1_updPte", {24'd0, updPte}, 32'h0000_00CB);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    checkStrobes(1'b0, "t1_pulseEnd", 6'b000000);
    checkOutput("t1_hold", updPpn, 32'h0004_8D14);

    // superpage on the D side
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0080_0000, 1'b0);
    c0 = cyc; tick();
    serveRead(1'b0, "t2", 32'h8000_0008, 32'h2000_00CF, 1'b0, 1'b0);
    checkStrobes(1'b0, "t2_done", 6'b000101);
    checkOutput("t2_latency", cyc - c0, 32'd3);
    checkOutput("t2_updLevel", updLevel, 32'd1);
    checkOutput("t2_updPpn", updPpn, 32'h0008_0000);
    checkOutput("t2_updVpn", updVpn, 32'h0000_0800);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();

    // misaligned superpage
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0080_0000, 1'b0); tick();
    serveRead(1'b0, "t2m", 32'h8000_0008, 32'h2000_04CF, 1'b0, 1'b0);
    checkStrobes(1'b0, "t2m_fault", 6'b000110);
    checkOutput("t2m_noUpd", updPpn, 32'h0008_0000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();

    // invalid L1 PTE
    applyStimulus(1'b1, 1'b0, 32'h0040_3ABC, 32'h0, 1'b0); tick();
    serveRead(1'b0, "t3a", 32'h8000_0004, 32'h0000_0000, 1'b0, 1'b0);
    checkStrobes(1'b0, "t3a_fault", 6'b110000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();

    // W without R
    applyStimulus(1'b1, 1'b0, 32'h0040_3ABC, 32'h0, 1'b0); tick();
    serveRead(1'b0, "t3b", 32'h8000_0004, 32'h2000_00C5, 1'b0, 1'b0);
    checkStrobes(1'b0, "t3b_fault", 6'b110000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();

    // pointer at level 0
    applyStimulus(1'b1, 1'b0, 32'h0040_3ABC, 32'h0, 1'b0); tick();
    serveRead(1'b0, "t3c_l1", 32'h8000_0004, 32'h2000_0001, 1'b0, 1'b0);
    serveRead(1'b0, "t3c_l0", 32'h8000_000C, 32'h2000_0001, 1'b0, 1'b0);
    checkStrobes(1'b0, "t3c_fault", 6'b110000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();

    // store to a leaf with D clear
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0080_0000, 1'b1); tick();
    serveRead(1'b0, "t3d", 32'h8000_0008, 32'h2000_004F, 1'b0, 1'b0);
    checkStrobes(1'b0, "t3d_fault", 6'b000110);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();

    // same leaf for a load is fine
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0080_0000, 1'b0); tick();
    serveRead(1'b0, "t3dl", 32'h8000_0008, 32'h2000_004F, 1'b0, 1'b0);
    checkStrobes(1'b0, "t3dl_ok", 6'b000101);
    checkOutput("t3dl_updPte", {24'd0, updPte}, 32'h0000_004F);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();

    // bus error
    applyStimulus(1'b1, 1'b0, 32'h0040_3ABC, 32'h0, 1'b0); tick();
    serveRead(1'b0, "t3e", 32'h8000_0004, 32'h2000_00CF, 1'b1, 1'b0);
    checkStrobes(1'b0, "t3e_fault", 6'b110000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();

    // round-robin: last grant was I, so D goes first
    applyStimulus(1'b1, 1'b1, 32'h0040_0000, 32'h0080_0000, 1'b0); tick();
    serveRead(1'b0, "t4_first", 32'h8000_0008, 32'h2000_00CF, 1'b0, 1'b0);
    checkStrobes(1'b0, "t4_firstD", 6'b000101);
    dReq = 1'b0; tick();
    serveRead(1'b0, "t4_second", 32'h8000_0004, 32'h2000_00CF, 1'b0, 1'b0);
    checkStrobes(1'b0, "t4_secondI", 6'b101000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();
    applyStimulus(1'b0, 1'b1, 32'h0040_0000, 32'h0080_0000, 1'b0); tick();
    serveRead(1'b0, "t4_donly", 32'h8000_0008, 32'h2000_00CF, 1'b0, 1'b0);
    checkStrobes(1'b0, "t4_donlyD", 6'b000101);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();
    // last grant was D, so I now wins
    applyStimulus(1'b1, 1'b1, 32'h0040_0000, 32'h0080_0000, 1'b0); tick();
    serveRead(1'b0, "t4_alt", 32'h8000_0004, 32'h2000_00CF, 1'b0, 1'b0);
    checkStrobes(1'b0, "t4_altI", 6'b101000);
    iReq = 1'b0; tick();
    serveRead(1'b0, "t4_alt2", 32'h8000_0008, 32'h2000_00CF, 1'b0, 1'b0);
    checkStrobes(1'b0, "t4_alt2D", 6'b000101);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();

    // fixed priority: D wins even right after a D walk
    iVaddr = 32'h0040_0000; dVaddr = 32'h0080_0000;
    dReq0 = 1'b1; tick();
    serveRead(1'b1, "t4f_donly", 32'h8000_0008, 32'h2000_00CF, 1'b0, 1'b0);
    checkStrobes(1'b1, "t4f_donlyD", 6'b000101);
    dReq0 = 1'b0; tick();
    iReq0 = 1'b1; dReq0 = 1'b1; tick();
    serveRead(1'b1, "t4f_first", 32'h8000_0008, 32'h2000_00CF, 1'b0, 1'b0);
    checkStrobes(1'b1, "t4f_firstD", 6'b000101);
    dReq0 = 1'b0; tick();
    serveRead(1'b1, "t4f_second", 32'h8000_0004, 32'h2000_00CF, 1'b0, 1'b0);
    checkStrobes(1'b1, "t4f_secondI", 6'b101000);
    iReq0 = 1'b0; tick();

    // flush during WAIT: done without update
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0080_0000, 1'b0); tick();
    serveRead(1'b0, "t5", 32'h8000_0008, 32'h2000_00CF, 1'b0, 1'b1);
    checkStrobes(1'b0, "t5_flush", 6'b000100);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();

    // backpressure then reset in WAIT
    memReqReady = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0040_3ABC, 32'h0, 1'b0); tick();
    for (int k = 0; k < 3; k++) begin
      checkOutput("t6_bpValid", {31'd0, memReqValid}, 32'd1);
      checkOutput("t6_bpAddr", memReqAddr, 32'h8000_0004);
      tick();
    end
    memReqReady = 1'b1; tick();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    reset = 1'b0;
    memRespValid = 1'b1; memRespData = 32'h2000_00CF; tick();
    memRespValid = 1'b0;
    checkStrobes(1'b0, "t6_lateResp", 6'b000000);
    checkOutput("t6_reqValid", {31'd0, memReqValid}, 32'd0);
    checkOutput("t6_updVpn", updVpn, 32'd0);
    tick();
    checkStrobes(1'b0, "t6_quiet", 6'b000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
